// File: rtl/fruit_pkg.sv
// Shared types and constants for the fruit launch scheduler.
// State encoding, LFSR seed/taps and launch-parameter field layout.
package fruit_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_PICK,
    S_LAUNCH,
    S_OVER
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int XS_W  = 10;
  localparam int INC_W = 11;

  localparam int XSTART_BASE = 64;
  localparam int X_CENTER    = 320;
  localparam int INC_BASE    = 4;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    lfsr_next = {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/fruit_launcher_if.sv
// Game-control and fruit-slot signals of the launcher.
// slave = launcher side, master = game / fruit side.
interface fruit_launcher_if #(
  parameter int N_SLOTS = 4
);
  logic                   game_enable;
  logic [N_SLOTS-1:0]     offstage;
  logic [N_SLOTS-1:0]     sliced;
  logic [N_SLOTS-1:0]     slot_reset;
  logic [10*N_SLOTS-1:0]  slot_xstart;
  logic [11*N_SLOTS-1:0]  slot_inc;
  logic [11*N_SLOTS-1:0]  slot_xinc;
  logic [N_SLOTS-1:0]     slot_negate;
  logic [N_SLOTS-1:0]     busy;
  logic [3:0]             miss_count;
  logic [7:0]             launched_count;
  logic                   game_over;

  modport slave (
    input  game_enable, offstage, sliced,
    output slot_reset, slot_xstart, slot_inc,
    output slot_xinc, slot_negate, busy,
    output miss_count, launched_count, game_over
  );

  modport master (
    output game_enable, offstage, sliced,
    input  slot_reset, slot_xstart, slot_inc,
    input  slot_xinc, slot_negate, busy,
    input  miss_count, launched_count, game_over
  );
endinterface

// File: rtl/fruit_lfsr.sv
// Free-running 16-bit Galois LFSR feeding launch parameters.
// Restarts from the seed on asynchronous reset.
module fruit_lfsr
  import fruit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // next value: one Galois shift per frame
  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  // state register, seeded on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/fruit_launcher.sv
// Shares N_SLOTS fruit instances between timed launches.
// Picks the lowest free slot, tracks releases, misses and game over.
module fruit_launcher
  import fruit_pkg::*;
#(
  parameter int N_SLOTS    = 4,
  parameter int LAUNCH_GAP = 60,
  parameter int MAX_MISS   = 3
) (
  input  logic             frame_clk,
  input  logic             Reset_n,
  fruit_launcher_if.slave  bus
);

  localparam int GW = (LAUNCH_GAP > 1) ? $clog2(LAUNCH_GAP) : 1;
  localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  function automatic logic [SW-1:0] lowest_free(
    input logic [N_SLOTS-1:0] free
  );
    lowest_free = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (free[i]) lowest_free = SW'(i);
    end
  endfunction

  state_e                          state_q, state_d;
  logic [GW-1:0]                   gap_q, gap_d;
  logic [SW-1:0]                   sel_q, sel_d;
  logic [N_SLOTS-1:0]              busy_q, busy_d;
  logic [N_SLOTS-1:0]              sres_q;
  logic [3:0]                      miss_q, miss_d;
  logic [7:0]                      launched_q, launched_d;
  logic [N_SLOTS-1:0][XS_W-1:0]    xs_q, xs_d;
  logic [N_SLOTS-1:0][INC_W-1:0]   inc_q, inc_d;
  logic [N_SLOTS-1:0][INC_W-1:0]   xinc_q, xinc_d;
  logic [N_SLOTS-1:0]              neg_q, neg_d;

  logic [15:0]          lfsr;
  logic                 unused_lfsr;
  logic [N_SLOTS-1:0]   rel;
  logic [N_SLOTS-1:0]   missv;
  logic [7:0]           nmiss;
  logic [7:0]           miss_sum;
  logic [3:0]           miss_sat;
  logic [SW-1:0]        pick_sel;
  logic [XS_W-1:0]      pk_xs;
  logic [INC_W-1:0]     pk_inc;
  logic [INC_W-1:0]     pk_xinc;
  logic                 pk_neg;

  fruit_lfsr u_lfsr (
    .clk_i   (frame_clk),
    .rst_ni  (Reset_n),
    .state_o (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:13];

  assign rel      = busy_q & (bus.sliced | bus.offstage);
  assign missv    = busy_q & bus.offstage & ~bus.sliced;
  assign pick_sel = lowest_free(~busy_q);

  assign pk_xs   = XS_W'(XSTART_BASE) + {1'b0, lfsr[8:0]};
  assign pk_inc  = INC_W'(INC_BASE)
                 + {{(INC_W-2){1'b0}}, lfsr[10:9]};
  assign pk_xinc = {{(INC_W-2){1'b0}}, lfsr[12:11]};
  assign pk_neg  = pk_xs >= XS_W'(X_CENTER);

  // misses this frame, added to the count with saturation at 15
  always_comb begin
    nmiss = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      nmiss = nmiss + {7'b0, missv[i]};
    end
    miss_sum = {4'b0, miss_q} + nmiss;
    miss_sat = (miss_sum > 8'd15) ? 4'd15 : miss_sum[3:0];
  end

  // next-state, slot bookkeeping and parameter capture
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    miss_d     = miss_q;
    launched_d = launched_q;
    xs_d       = xs_q;
    inc_d      = inc_q;
    xinc_d     = xinc_q;
    neg_d      = neg_q;
    if (state_q == S_IDLE) begin
      busy_d     = '0;
      miss_d     = '0;
      launched_d = '0;
      if (bus.game_enable) begin
        gap_d   = GW'(LAUNCH_GAP - 1);
        state_d = S_GAP;
      end
    end else if (state_q == S_OVER) begin
      busy_d = '0;
      if (!bus.game_enable) state_d = S_IDLE;
    end else if (!bus.game_enable) begin
      busy_d  = '0;
      state_d = S_IDLE;
    end else if (miss_sat >= 4'(MAX_MISS)) begin
      busy_d  = '0;
      miss_d  = miss_sat;
      state_d = S_OVER;
    end else begin
      busy_d = busy_q & ~rel;
      miss_d = miss_sat;
      unique case (state_q)
        S_GAP: begin
          if (gap_q == '0) state_d = S_PICK;
          else             gap_d   = gap_q - GW'(1);
        end
        S_PICK: begin
          if (|(~busy_q)) begin
            sel_d           = pick_sel;
            xs_d[pick_sel]  = pk_xs;
            inc_d[pick_sel] = pk_inc;
            xinc_d[pick_sel]= pk_xinc;
            neg_d[pick_sel] = pk_neg;
            state_d         = S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          busy_d[sel_q] = 1'b1;
          launched_d    = launched_q + 8'd1;
          gap_d         = GW'(LAUNCH_GAP - 1);
          state_d       = S_GAP;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // state and slot registers; fruit Reset follows ~busy a frame late
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      gap_q      <= '0;
      sel_q      <= '0;
      busy_q     <= '0;
      sres_q     <= '1;
      miss_q     <= '0;
      launched_q <= '0;
      xs_q       <= '0;
      inc_q      <= '0;
      xinc_q     <= '0;
      neg_q      <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      sres_q     <= ~busy_q;
      miss_q     <= miss_d;
      launched_q <= launched_d;
      xs_q       <= xs_d;
      inc_q      <= inc_d;
      xinc_q     <= xinc_d;
      neg_q      <= neg_d;
    end
  end

  assign bus.slot_reset     = sres_q;
  assign bus.slot_xstart    = xs_q;
  assign bus.slot_inc       = inc_q;
  assign bus.slot_xinc      = xinc_q;
  assign bus.slot_negate    = neg_q;
  assign bus.busy           = busy_q;
  assign bus.miss_count     = miss_q;
  assign bus.launched_count = launched_q;
  assign bus.game_over      = (state_q == S_OVER);

endmodule

// File: tb/tb_fruit_launcher.sv
// Bench for fruit_launcher: startup table, directed corners,
// then random play against a behavioural model.
module tb_fruit_launcher;

  localparam int N    = 4;
  localparam int LG   = 4;
  localparam int MAXM = 3;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_OVER = 2;

  logic frame_clk = 1'b0;
  logic Reset_n;

  always #5 frame_clk = ~frame_clk;

  fruit_launcher_if #(.N_SLOTS(N)) bus ();

  fruit_launcher #(
    .N_SLOTS    (N),
    .LAUNCH_GAP (LG),
    .MAX_MISS   (MAXM)
  ) dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  int          m_mode;
  int          m_wait;
  int          m_pend;
  int          m_miss;
  int          m_launched;
  logic [15:0] m_lfsr;
  logic [3:0]  m_busy;
  logic [3:0]  m_sres;
  int          m_xs   [N];
  int          m_inc  [N];
  int          m_xinc [N];
  bit          m_neg  [N];

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic m_reset();
    m_mode     = M_IDLE;
    m_wait     = 0;
    m_pend     = -1;
    m_miss     = 0;
    m_launched = 0;
    m_lfsr     = 16'hACE1;
    m_busy     = '0;
    m_sres     = 4'hF;
    for (int i = 0; i < N; i++) begin
      m_xs[i] = 0; m_inc[i] = 0; m_xinc[i] = 0; m_neg[i] = 0;
    end
  endtask

  task automatic m_step();
    logic [3:0] old;
    int nm;
    bit found;
    old    = m_busy;
    m_sres = ~old;
    case (m_mode)
      M_IDLE: begin
        m_busy = '0; m_miss = 0; m_launched = 0;
        if (bus.game_enable) begin
          m_mode = M_RUN; m_wait = LG; m_pend = -1;
        end
      end
      M_RUN: begin
        if (!bus.game_enable) begin
          m_mode = M_IDLE; m_busy = '0;
        end else begin
          nm = 0;
          for (int i = 0; i < N; i++)
            if (old[i] && bus.offstage[i] && !bus.sliced[i]) nm++;
          nm = m_miss + nm;
          if (nm > 15) nm = 15;
          m_miss = nm;
          if (nm >= MAXM) begin
            m_mode = M_OVER; m_busy = '0;
          end else begin
            for (int i = 0; i < N; i++)
              if (old[i] && (bus.offstage[i] || bus.sliced[i]))
                m_busy[i] = 1'b0;
            if (m_wait > 0) begin
              m_wait--;
            end else if (m_pend >= 0) begin
              m_busy[m_pend] = 1'b1;
              m_launched = (m_launched + 1) % 256;
              m_wait = LG;
              m_pend = -1;
            end else begin
              found = 0;
              for (int i = 0; i < N; i++) begin
                if (!found && !old[i]) begin
                  found     = 1;
                  m_pend    = i;
                  m_xs[i]   = 64 + int'(m_lfsr & 16'h01FF);
                  m_inc[i]  = 4 + int'((m_lfsr >> 9) & 16'h3);
                  m_xinc[i] = int'((m_lfsr >> 11) & 16'h3);
                  m_neg[i]  = (m_xs[i] >= 320);
                end
              end
            end
          end
        end
      end
      default: begin
        m_busy = '0;
        if (!bus.game_enable) m_mode = M_IDLE;
      end
    endcase
    m_lfsr = lstep(m_lfsr);
  endtask

  always @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) m_reset();
    else          m_step();
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all();
    logic [39:0] exs;
    logic [43:0] einc;
    logic [43:0] exinc;
    logic [3:0]  eneg;
    for (int i = 0; i < N; i++) begin
      exs[10*i +: 10]   = 10'(m_xs[i]);
      einc[11*i +: 11]  = 11'(m_inc[i]);
      exinc[11*i +: 11] = 11'(m_xinc[i]);
      eneg[i]           = m_neg[i];
    end
    chk("busy", bus.busy, m_busy);
    chk("slot_reset", bus.slot_reset, m_sres);
    chk("miss_count", bus.miss_count, 4'(m_miss));
    chk("launched_count", bus.launched_count, 8'(m_launched));
    chk("game_over", bus.game_over, m_mode == M_OVER);
    chk("slot_xstart", bus.slot_xstart, exs);
    chk("slot_inc", bus.slot_inc, einc);
    chk("slot_xinc", bus.slot_xinc, exinc);
    chk("slot_negate", bus.slot_negate, eneg);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_slot_reset"}, bus.slot_reset, 4'hF);
    chk({tag, "_busy"}, bus.busy, 4'h0);
    chk({tag, "_miss"}, bus.miss_count, 4'h0);
    chk({tag, "_launched"}, bus.launched_count, 8'h00);
    chk({tag, "_game_over"}, bus.game_over, 1'b0);
    chk({tag, "_xstart"}, bus.slot_xstart, 40'h0);
    chk({tag, "_inc"}, bus.slot_inc, 44'h0);
  endtask

  task automatic tick();
    @(negedge frame_clk);
  endtask

  task automatic wait_busy(input logic [3:0] target, input int budget,
                           input string nm);
    int n;
    n = 0;
    while (bus.busy !== target && n < budget) begin
      tick();
      check_all();
      n++;
    end
    chk(nm, bus.busy, target);
  endtask

  typedef struct {
    logic       en;
    logic [3:0] off;
    logic [3:0] sl;
    logic [3:0] busy;
    logic [3:0] sres;
    logic [7:0] launched;
    logic [3:0] miss;
    logic       go;
  } vec_t;

  vec_t tv [14];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] l;
    int n;

    for (int k = 1; k <= 14; k++) begin
      tv[k-1].en       = 1'b1;
      tv[k-1].off      = 4'h0;
      tv[k-1].sl       = 4'h0;
      tv[k-1].busy     = (k >= 13) ? 4'h3 : (k >= 7) ? 4'h1 : 4'h0;
      tv[k-1].sres     = (k >= 14) ? 4'hC : (k >= 8) ? 4'hE : 4'hF;
      tv[k-1].launched = (k >= 13) ? 8'd2 : (k >= 7) ? 8'd1 : 8'd0;
      tv[k-1].miss     = 4'h0;
      tv[k-1].go       = 1'b0;
    end

    Reset_n         = 1'b0;
    bus.game_enable = 1'b1;
    bus.offstage    = '0;
    bus.sliced      = '0;
    tick();
    tick();
    check_reset_vals("reset");
    Reset_n = 1'b1;

    // startup cadence with LAUNCH_GAP=4
    for (int r = 0; r < 14; r++) begin
      bus.game_enable = tv[r].en;
      bus.offstage    = tv[r].off;
      bus.sliced      = tv[r].sl;
      tick();
      chk($sformatf("tv%0d_busy", r), bus.busy, tv[r].busy);
      chk($sformatf("tv%0d_sres", r), bus.slot_reset, tv[r].sres);
      chk($sformatf("tv%0d_launched", r), bus.launched_count,
          tv[r].launched);
      chk($sformatf("tv%0d_miss", r), bus.miss_count, tv[r].miss);
      chk($sformatf("tv%0d_go", r), bus.game_over, tv[r].go);
      check_all();
    end

    // all slots busy: PICK holds
    wait_busy(4'hF, 60, "fill_all");
    chk("fill_launched", bus.launched_count, 8'd4);
    for (int i = 0; i < 20; i++) begin tick(); check_all(); end
    chk("hold_launched", bus.launched_count, 8'd4);
    chk("hold_busy", bus.busy, 4'hF);

    // slice slot 2 -> relaunch into slot 2
    bus.sliced = 4'b0100;
    tick();
    bus.sliced = 4'b0000;
    chk("slice2_busy", bus.busy, 4'hB);
    chk("slice2_miss", bus.miss_count, 4'd0);
    check_all();
    wait_busy(4'hF, 20, "refill_slot2");
    chk("refill_launched", bus.launched_count, 8'd5);

    // miss on busy slot 1, then offstage on the now idle slot 1
    bus.offstage = 4'b0010;
    tick();
    chk("miss1_busy", bus.busy, 4'hD);
    chk("miss1_count", bus.miss_count, 4'd1);
    check_all();
    tick();
    bus.offstage = 4'b0000;
    chk("idle_off_busy", bus.busy, 4'hD);
    chk("idle_off_miss", bus.miss_count, 4'd1);
    check_all();
    wait_busy(4'hF, 40, "refill_slot1");

    // slice and offstage together count as slice
    bus.sliced   = 4'b0001;
    bus.offstage = 4'b0001;
    tick();
    bus.sliced   = 4'b0000;
    bus.offstage = 4'b0000;
    chk("both_busy", bus.busy, 4'hE);
    chk("both_miss", bus.miss_count, 4'd1);
    check_all();
    wait_busy(4'hF, 40, "refill_slot0");

    // two misses at once reach MAX_MISS
    bus.offstage = 4'b1100;
    tick();
    bus.offstage = 4'b0000;
    chk("over_go", bus.game_over, 1'b1);
    chk("over_miss", bus.miss_count, 4'd3);
    chk("over_busy", bus.busy, 4'h0);
    check_all();
    tick();
    chk("over_sres", bus.slot_reset, 4'hF);
    for (int i = 0; i < 10; i++) begin tick(); check_all(); end
    chk("over_launched", bus.launched_count, 8'd7);
    chk("over_go_hold", bus.game_over, 1'b1);
    bus.game_enable = 1'b0;
    tick();
    chk("exit_go", bus.game_over, 1'b0);
    check_all();
    tick();
    chk("idle_miss", bus.miss_count, 4'd0);
    chk("idle_launched", bus.launched_count, 8'd0);
    check_all();

    // async reset during LAUNCH
    bus.game_enable = 1'b1;
    n = 0;
    while (!(m_mode == M_RUN && m_wait == 0 && m_pend >= 0) && n < 50) begin
      tick();
      check_all();
      n++;
    end
    chk("reach_launch", n < 50, 1'b1);
    Reset_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    tick();
    check_reset_vals("mid_rst_hold");
    Reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(); check_all(); end
    l = 16'hACE1;
    for (int i = 0; i < 5; i++) l = lstep(l);
    chk("seed_xstart0", bus.slot_xstart[9:0], 10'd64 + {1'b0, l[8:0]});
    chk("seed_inc0", bus.slot_inc[10:0], 11'd4 + {9'd0, l[10:9]});

    // random play
    for (int c = 0; c < 3000; c++) begin
      bus.game_enable = ($urandom_range(0, 99) < 97);
      for (int i = 0; i < N; i++) begin
        bus.offstage[i] = ($urandom_range(0, 99) < 4);
        bus.sliced[i]   = ($urandom_range(0, 99) < 7);
      end
      tick();
      check_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
